// File: rtl/dbus_arbiter.sv
// Two-master D-bus arbiter: serialises CPU data port (m0) and debug SBA (m1) onto one slave port.
// Optional macro DBUS_ARB_RR_EN switches tie-breaking from fixed m1 priority to alternating grants.
module dbus_arbiter #(
   parameter int AW             = 32,
   parameter int DW             = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          m0_req,
   input  logic [AW-1:0] m0_addr,
   input  logic          m0_ttype,
   input  logic [1:0]    m0_tsize,
   input  logic [DW-1:0] m0_wdata,
   output logic [DW-1:0] m0_rdata,
   output logic          m0_done,
   output logic          m0_err,
   input  logic          m1_req,
   input  logic [AW-1:0] m1_addr,
   input  logic          m1_ttype,
   input  logic [1:0]    m1_tsize,
   input  logic [DW-1:0] m1_wdata,
   output logic [DW-1:0] m1_rdata,
   output logic          m1_done,
   output logic          m1_err,
   output logic          s_start,
   output logic [AW-1:0] s_addr,
   output logic          s_ttype,
   output logic [1:0]    s_tsize,
   output logic [DW-1:0] s_wdata,
   input  logic [DW-1:0] s_rdata,
   input  logic          s_done,
   output logic          busy,
   output logic          owner
);

   localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt;
   logic          resp_err;
   logic          grant_vld;
   logic          grant_sel;
   logic          timeout_hit;

   assign grant_vld   = m0_req | m1_req;
   assign timeout_hit = (cnt == CW'(TIMEOUT_CYCLES - 1));

`ifdef DBUS_ARB_RR_EN
   logic last_grant;

   // On a tie the master that did not win last time gets the bus.
   always_comb begin
      grant_sel = m1_req;
      if (m0_req && m1_req)
         grant_sel = ~last_grant;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         last_grant <= 1'b1;
      else if (state == IDLE && grant_vld)
         last_grant <= grant_sel;
   end
`else
   always_comb begin
      grant_sel = m1_req;
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant_vld) state_nxt = ISSUE;
         ISSUE:   state_nxt = WAIT;
         WAIT:    if (s_done || timeout_hit) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner    <= 1'b0;
         s_addr   <= '0;
         s_ttype  <= 1'b0;
         s_tsize  <= 2'd0;
         s_wdata  <= '0;
         cnt      <= '0;
         resp_err <= 1'b0;
         m0_rdata <= '0;
         m1_rdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (grant_vld) begin
                  owner    <= grant_sel;
                  s_addr   <= grant_sel ? m1_addr  : m0_addr;
                  s_ttype  <= grant_sel ? m1_ttype : m0_ttype;
                  s_tsize  <= grant_sel ? m1_tsize : m0_tsize;
                  s_wdata  <= grant_sel ? m1_wdata : m0_wdata;
                  resp_err <= 1'b0;
               end
            end
            ISSUE: cnt <= '0;
            WAIT: begin
               // A slave completion in the timeout cycle still counts as success.
               if (s_done) begin
                  resp_err <= 1'b0;
                  if (!s_ttype) begin
                     if (owner) m1_rdata <= s_rdata;
                     else       m0_rdata <= s_rdata;
                  end
               end else if (timeout_hit) begin
                  resp_err <= 1'b1;
                  if (owner) m1_rdata <= '0;
                  else       m0_rdata <= '0;
               end else if (cnt != '1) begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign s_start = (state == ISSUE);
   assign busy    = (state != IDLE);
   assign m0_done = (state == RESP) && !owner;
   assign m1_done = (state == RESP) &&  owner;
   assign m0_err  = m0_done && resp_err;
   assign m1_err  = m1_done && resp_err;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Testbench for dbus_arbiter: directed scenarios plus randomized transactions against a grant/response model.
module tb_dbus_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int T  = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          m0_req, m1_req;
   logic [AW-1:0] m0_addr, m1_addr;
   logic          m0_ttype, m1_ttype;
   logic [1:0]    m0_tsize, m1_tsize;
   logic [DW-1:0] m0_wdata, m1_wdata;
   logic [DW-1:0] m0_rdata, m1_rdata;
   logic          m0_done, m1_done, m0_err, m1_err;
   logic          s_start, s_ttype, s_done, busy, owner;
   logic [AW-1:0] s_addr;
   logic [1:0]    s_tsize;
   logic [DW-1:0] s_wdata, s_rdata;

   dbus_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_ttype(m0_ttype), .m0_tsize(m0_tsize),
      .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_done(m0_done), .m0_err(m0_err),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_ttype(m1_ttype), .m1_tsize(m1_tsize),
      .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_done(m1_done), .m1_err(m1_err),
      .s_start(s_start), .s_addr(s_addr), .s_ttype(s_ttype), .s_tsize(s_tsize),
      .s_wdata(s_wdata), .s_rdata(s_rdata), .s_done(s_done), .busy(busy), .owner(owner)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   // Reference model state: per-master held read data and round-robin history.
   logic [DW-1:0] mdl_rd [2];
   bit            mdl_last;

   // Observations from the most recent transaction.
   int            o_start_off, o_start_cnt, o_done_off, o_d0cnt, o_d1cnt, o_stray_err;
   bit            o_err, o_owner, o_stable, o_idle_after;
   logic [DW-1:0] o_rd0, o_rd1;
   logic [AW-1:0] o_saddr;
   logic          o_sttype;
   logic [1:0]    o_stsize;
   logic [DW-1:0] o_swdata;

   function automatic bit model_grant(input bit r0, input bit r1);
      bit w;
      w = r1;
`ifdef DBUS_ARB_RR_EN
      if (r0 && r1) w = ~mdl_last;
      mdl_last = w;
`endif
      return w;
   endfunction

   function automatic bit lat_ok(input int lat);
      return (lat >= 0) && (lat <= T - 1);
   endfunction

   function automatic int model_done_off(input int lat);
      return lat_ok(lat) ? 3 + lat : 2 + T;
   endfunction

   function automatic void model_resp(input bit w, input bit ttype, input int lat,
                                      input logic [DW-1:0] sdata);
      if (!lat_ok(lat)) mdl_rd[w] = '0;
      else if (!ttype)  mdl_rd[w] = sdata;
   endfunction

   function automatic void model_reset();
      mdl_rd[0] = '0;
      mdl_rd[1] = '0;
      mdl_last  = 1'b1;
   endfunction

   // Drives one arbitration round from IDLE and records what the DUT did; no checking here.
   task automatic run_txn(input bit r0, input bit r1, input int lat,
                          input logic [DW-1:0] sdata, input bit spur);
      o_start_off = -1; o_start_cnt = 0; o_done_off = -1; o_d0cnt = 0; o_d1cnt = 0;
      o_stray_err = 0; o_err = 0; o_stable = 1; o_idle_after = 0; o_owner = 0;
      @(posedge clk); #1;
      m0_req = r0;
      m1_req = r1;
      for (int off = 0; off < 40; off++) begin
         s_done  = (lat >= 0 && off == 2 + lat) || (spur && off == 1);
         s_rdata = (spur && off == 1) ? ~sdata : (s_done ? sdata : DW'($urandom));
         @(negedge clk);
         if (s_start) begin
            if (o_start_off < 0) o_start_off = off;
            o_start_cnt++;
         end
         if (off == 1) begin
            o_owner = owner; o_saddr = s_addr; o_sttype = s_ttype;
            o_stsize = s_tsize; o_swdata = s_wdata;
         end else if (off > 1 && (o_done_off < 0) &&
                      (s_addr !== o_saddr || s_ttype !== o_sttype ||
                       s_tsize !== o_stsize || s_wdata !== o_swdata)) begin
            o_stable = 0;
         end
         if ((m0_err && !m0_done) || (m1_err && !m1_done)) o_stray_err++;
         if (m0_done) o_d0cnt++;
         if (m1_done) o_d1cnt++;
         if ((m0_done || m1_done) && o_done_off < 0) begin
            o_done_off = off;
            o_err = m0_done ? m0_err : m1_err;
            o_rd0 = m0_rdata;
            o_rd1 = m1_rdata;
         end
         if (o_done_off >= 0 && off == o_done_off + 1) begin
            o_idle_after = !busy;
            break;
         end
         @(posedge clk); #1;
         if (o_done_off >= 0) begin
            m0_req = 1'b0;
            m1_req = 1'b0;
         end
      end
      s_done = 1'b0;
      m0_req = 1'b0;
      m1_req = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_chk++;
      if ({s_start, s_addr, s_ttype, s_tsize, s_wdata, m0_rdata, m1_rdata, m0_done, m1_done,
           m0_err, m1_err, busy, owner} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got s_addr=%h s_wdata=%h rd0=%h rd1=%h busy=%b owner=%b start=%b, required all 0",
                  s_addr, s_wdata, m0_rdata, m1_rdata, busy, owner, s_start);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_read();
      bit w;
      m0_addr = 32'h0000_0010; m0_ttype = 1'b0; m0_tsize = 2'd2; m0_wdata = 32'h1111_2222;
      w = model_grant(1, 0);
      model_resp(w, 1'b0, 0, 32'hDEAD_BEEF);
      run_txn(1, 0, 0, 32'hDEAD_BEEF, 0);
      n_chk++; if (o_start_off !== 1) begin n_fail++; $display("FAIL read_start_off: got %0d required 1", o_start_off); end
      n_chk++; if (o_start_cnt !== 1) begin n_fail++; $display("FAIL read_start_len: got %0d required 1", o_start_cnt); end
      n_chk++; if (o_done_off !== 3) begin n_fail++; $display("FAIL read_done_off: got %0d required 3", o_done_off); end
      n_chk++; if (o_rd0 !== mdl_rd[0]) begin n_fail++; $display("FAIL read_rdata: got %h required %h", o_rd0, mdl_rd[0]); end
      n_chk++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL read_err: got %b required 0", o_err); end
      n_chk++; if (o_d1cnt !== 0 || o_d0cnt !== 1) begin n_fail++; $display("FAIL read_done_count: got m0=%0d m1=%0d required 1/0", o_d0cnt, o_d1cnt); end
      n_chk++; if (o_idle_after !== 1'b1) begin n_fail++; $display("FAIL read_idle_after: got %b required 1", o_idle_after); end
   endtask

   task automatic test_write();
      bit w;
      m1_addr = 32'h2000_0004; m1_ttype = 1'b1; m1_tsize = 2'd0; m1_wdata = 32'h0000_00A5;
      w = model_grant(0, 1);
      model_resp(w, 1'b1, 2, 32'h7777_7777);
      run_txn(0, 1, 2, 32'h7777_7777, 0);
      n_chk++; if (o_owner !== 1'b1) begin n_fail++; $display("FAIL write_owner: got %b required 1", o_owner); end
      n_chk++; if ({o_saddr, o_sttype, o_stsize, o_swdata} !== {32'h2000_0004, 1'b1, 2'd0, 32'h0000_00A5}) begin
         n_fail++; $display("FAIL write_fields: got %h/%b/%0d/%h required 20000004/1/0/000000a5", o_saddr, o_sttype, o_stsize, o_swdata);
      end
      n_chk++; if (o_stable !== 1'b1) begin n_fail++; $display("FAIL write_stable: got %b required 1", o_stable); end
      n_chk++; if (o_d1cnt !== 1 || o_d0cnt !== 0) begin n_fail++; $display("FAIL write_done_count: got m0=%0d m1=%0d required 0/1", o_d0cnt, o_d1cnt); end
      n_chk++; if (o_done_off !== 5) begin n_fail++; $display("FAIL write_done_off: got %0d required 5", o_done_off); end
      n_chk++; if (o_rd1 !== mdl_rd[1]) begin n_fail++; $display("FAIL write_rdata_kept: got %h required %h", o_rd1, mdl_rd[1]); end
   endtask

   task automatic test_tie();
      bit w;
      test_reset();
      for (int i = 0; i < 4; i++) begin
         m0_addr = 32'h100 + 32'(i); m0_ttype = 1'b0; m0_tsize = 2'd2;
         m1_addr = 32'h200 + 32'(i); m1_ttype = 1'b0; m1_tsize = 2'd2;
         w = model_grant(1, 1);
         model_resp(w, 1'b0, 0, 32'hA000_0000 + 32'(i));
         run_txn(1, 1, 0, 32'hA000_0000 + 32'(i), 0);
         n_chk++; if (o_owner !== w) begin n_fail++; $display("FAIL tie_grant_%0d: got %b required %b", i, o_owner, w); end
         n_chk++; if (o_saddr !== (w ? m1_addr : m0_addr)) begin n_fail++; $display("FAIL tie_addr_%0d: got %h required %h", i, o_saddr, w ? m1_addr : m0_addr); end
         n_chk++; if ((w ? o_d0cnt : o_d1cnt) !== 0) begin n_fail++; $display("FAIL tie_loser_done_%0d: got %0d required 0", i, w ? o_d0cnt : o_d1cnt); end
      end
   endtask

   task automatic test_timeout();
      bit w;
      m0_addr = 32'h0000_0040; m0_ttype = 1'b0; m0_tsize = 2'd2;
      w = model_grant(1, 0);
      model_resp(w, 1'b0, -1, '0);
      run_txn(1, 0, -1, '0, 0);
      n_chk++; if (o_done_off !== 2 + T) begin n_fail++; $display("FAIL timeout_done_off: got %0d required %0d", o_done_off, 2 + T); end
      n_chk++; if (o_err !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got %b required 1", o_err); end
      n_chk++; if (o_rd0 !== 32'h0) begin n_fail++; $display("FAIL timeout_rdata: got %h required 0", o_rd0); end
      n_chk++; if (o_idle_after !== 1'b1) begin n_fail++; $display("FAIL timeout_idle_after: got %b required 1", o_idle_after); end
      n_chk++; if (o_d0cnt !== 1) begin n_fail++; $display("FAIL timeout_done_len: got %0d required 1", o_d0cnt); end
      w = model_grant(1, 0);
      model_resp(w, 1'b0, T - 1, 32'hC0FF_EE00);
      run_txn(1, 0, T - 1, 32'hC0FF_EE00, 0);
      n_chk++; if (o_done_off !== 2 + T) begin n_fail++; $display("FAIL lastwait_done_off: got %0d required %0d", o_done_off, 2 + T); end
      n_chk++; if (o_err !== 1'b0) begin n_fail++; $display("FAIL lastwait_err: got %b required 0", o_err); end
      n_chk++; if (o_rd0 !== 32'hC0FF_EE00) begin n_fail++; $display("FAIL lastwait_rdata: got %h required c0ffee00", o_rd0); end
   endtask

   task automatic test_rst_mid();
      int dones;
      bit w;
      m0_addr = 32'h0000_0080; m0_ttype = 1'b0; m0_tsize = 2'd2;
      @(posedge clk); #1;
      m0_req = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b1;
      #1;
      n_chk++;
      if ({s_start, s_addr, s_ttype, s_tsize, s_wdata, m0_rdata, m1_rdata, m0_done, m1_done,
           m0_err, m1_err, busy, owner} !== '0) begin
         n_fail++;
         $display("FAIL rst_mid_outputs: got s_addr=%h rd0=%h rd1=%h busy=%b owner=%b, required all 0",
                  s_addr, m0_rdata, m1_rdata, busy, owner);
      end
      @(posedge clk); #1;
      m0_req = 1'b0;
      rst = 1'b0;
      model_reset();
      dones = 0;
      repeat (T + 4) begin
         @(negedge clk);
         if (m0_done || m1_done || busy) dones++;
      end
      n_chk++; if (dones !== 0) begin n_fail++; $display("FAIL rst_mid_dropped: got %0d done/busy cycles required 0", dones); end
      w = model_grant(1, 0);
      model_resp(w, 1'b0, 1, 32'h1234_5678);
      run_txn(1, 0, 1, 32'h1234_5678, 0);
      n_chk++; if (o_done_off !== 4) begin n_fail++; $display("FAIL rst_mid_fresh_off: got %0d required 4", o_done_off); end
      n_chk++; if (o_rd0 !== 32'h1234_5678 || o_err !== 1'b0) begin n_fail++; $display("FAIL rst_mid_fresh_data: got %h err %b required 12345678 err 0", o_rd0, o_err); end
   endtask

   task automatic test_sdone_idle();
      int bad;
      bad = 0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         s_done  = 1'b1;
         s_rdata = DW'($urandom);
         @(negedge clk);
         if (busy || m0_done || m1_done || s_start) bad++;
      end
      @(posedge clk); #1;
      s_done = 1'b0;
      @(negedge clk);
      if (busy || m0_done || m1_done || s_start) bad++;
      n_chk++; if (bad !== 0) begin n_fail++; $display("FAIL sdone_idle: got %0d active cycles required 0", bad); end
      n_chk++; if (m0_rdata !== mdl_rd[0] || m1_rdata !== mdl_rd[1]) begin
         n_fail++; $display("FAIL sdone_idle_rdata: got %h/%h required %h/%h", m0_rdata, m1_rdata, mdl_rd[0], mdl_rd[1]);
      end
   endtask

   task automatic test_random();
      bit r0, r1, w, tt;
      int lat;
      logic [DW-1:0] sd;
      for (int i = 0; i < 30; i++) begin
         r0 = 1'($urandom); r1 = 1'($urandom);
         if (!r0 && !r1) r0 = 1'b1;
         m0_addr = AW'($urandom); m0_ttype = 1'($urandom); m0_tsize = 2'($urandom_range(0, 2)); m0_wdata = DW'($urandom);
         m1_addr = AW'($urandom); m1_ttype = 1'($urandom); m1_tsize = 2'($urandom_range(0, 2)); m1_wdata = DW'($urandom);
         lat = $urandom_range(0, T + 2) - 1;
         sd  = DW'($urandom);
         w   = model_grant(r0, r1);
         tt  = w ? m1_ttype : m0_ttype;
         model_resp(w, tt, lat, sd);
         run_txn(r0, r1, lat, sd, 1'($urandom));
         n_chk++; if (o_owner !== w) begin n_fail++; $display("FAIL rnd_owner_%0d: got %b required %b", i, o_owner, w); end
         n_chk++; if ({o_saddr, o_sttype, o_stsize, o_swdata} !== (w ? {m1_addr, m1_ttype, m1_tsize, m1_wdata} : {m0_addr, m0_ttype, m0_tsize, m0_wdata})) begin
            n_fail++; $display("FAIL rnd_fields_%0d: got %h/%b/%0d/%h", i, o_saddr, o_sttype, o_stsize, o_swdata);
         end
         n_chk++; if (o_stable !== 1'b1 || o_start_cnt !== 1 || o_start_off !== 1) begin
            n_fail++; $display("FAIL rnd_issue_%0d: got stable=%b starts=%0d at %0d required 1/1/1", i, o_stable, o_start_cnt, o_start_off);
         end
         n_chk++; if (o_done_off !== model_done_off(lat)) begin n_fail++; $display("FAIL rnd_done_off_%0d: got %0d required %0d", i, o_done_off, model_done_off(lat)); end
         n_chk++; if (o_err !== !lat_ok(lat)) begin n_fail++; $display("FAIL rnd_err_%0d: got %b required %b", i, o_err, !lat_ok(lat)); end
         n_chk++; if (o_rd0 !== mdl_rd[0] || o_rd1 !== mdl_rd[1]) begin
            n_fail++; $display("FAIL rnd_rdata_%0d: got %h/%h required %h/%h", i, o_rd0, o_rd1, mdl_rd[0], mdl_rd[1]);
         end
         n_chk++; if (o_d0cnt !== int'(!w) || o_d1cnt !== int'(w) || o_stray_err !== 0) begin
            n_fail++; $display("FAIL rnd_done_pulses_%0d: got m0=%0d m1=%0d stray_err=%0d", i, o_d0cnt, o_d1cnt, o_stray_err);
         end
         n_chk++; if (o_idle_after !== 1'b1) begin n_fail++; $display("FAIL rnd_idle_after_%0d: got %b required 1", i, o_idle_after); end
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      m0_req = 0; m1_req = 0; s_done = 0; s_rdata = '0;
      m0_addr = '0; m0_ttype = 0; m0_tsize = 0; m0_wdata = '0;
      m1_addr = '0; m1_ttype = 0; m1_tsize = 0; m1_wdata = '0;
      model_reset();
      test_reset();
      test_read();
      test_write();
      test_tie();
      test_timeout();
      test_rst_mid();
      test_sdone_idle();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
